sa_output_drain: RTL

//  Downstream of sa_compute: accepts skewed per-column partial sums (column j of a result row arrives
//  j cycles after column 0), deskews them into a full row and writes one row per word to the output
//  mem_simple. Programmed per job with base address + row count; pulses o_done when the last row is written.

---
 rtl/sa_output_drain.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sa_output_drain.sv
// Deskews column-skewed systolic partial sums into full rows and writes one row per memory word.
// i_valid to memory write is NUM_COLS cycles; no backpressure, one row per cycle sustained.
module sa_output_drain #(
    parameter int ADD_DATAWIDTH = 32,
    parameter int NUM_COLS      = 4,
    parameter int MEM_ROWS      = 8,
    localparam int AW = (MEM_ROWS > 1) ? $clog2(MEM_ROWS) : 1,
    localparam int RW = ADD_DATAWIDTH * NUM_COLS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_num_rows,
    input  logic          i_valid,
    input  logic [RW-1:0] i_psum,
    output logic          o_cenb,
    output logic          o_wenb,
    output logic [AW-1:0] o_addr,
    output logic [RW-1:0] o_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [AW:0] DEPTH = (AW+1)'(MEM_ROWS);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] base_q;
    logic [AW:0]   rows_q, accepted_q, written_q;
    logic          cenb_q, err_q;
    logic [AW-1:0] addr_q;
    logic [RW-1:0] data_q;

    logic          tag_in, tag_out;
    logic [RW-1:0] row_aligned;
    logic [AW:0]   wr_sum;
    logic [AW-1:0] wr_addr;

    // Only rows arriving while capturing and still within the job count get a write tag.
    assign tag_in = i_valid && (state_q == ST_CAPTURE) && (accepted_q < rows_q);

    if (NUM_COLS > 1) begin : g_tag
        logic [NUM_COLS-2:0] tag_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q <= '0;
            end else begin
                tag_q[0] <= tag_in;
                for (int k = 1; k < NUM_COLS-1; k++) tag_q[k] <= tag_q[k-1];
            end
        end
        assign tag_out = tag_q[NUM_COLS-2];
    end else begin : g_notag
        assign tag_out = tag_in;
    end

    // Column j shows up j cycles late, so it needs NUM_COLS-1-j stages to line up with the last column.
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
        localparam int D = NUM_COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign row_aligned[ADD_DATAWIDTH*(j+1)-1 -: ADD_DATAWIDTH] =
                i_psum[ADD_DATAWIDTH*(j+1)-1 -: ADD_DATAWIDTH];
        end else begin : g_dly
            logic [ADD_DATAWIDTH-1:0] dly_q [D];
            always_ff @(posedge clk) begin
                dly_q[0] <= i_psum[ADD_DATAWIDTH*(j+1)-1 -: ADD_DATAWIDTH];
                for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
            end
            assign row_aligned[ADD_DATAWIDTH*(j+1)-1 -: ADD_DATAWIDTH] = dly_q[D-1];
        end
    end

    assign wr_sum  = {1'b0, base_q} + written_q;
    assign wr_addr = (wr_sum >= DEPTH) ? AW'(wr_sum - DEPTH) : AW'(wr_sum);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_start) state_d = (i_num_rows == '0) ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: if (tag_in && (accepted_q + ONE == rows_q)) state_d = ST_FLUSH;
            ST_FLUSH:   if (!cenb_q && (written_q == rows_q)) state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            rows_q     <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            cenb_q     <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && i_start) begin
                base_q     <= i_base_addr;
                rows_q     <= i_num_rows;
                accepted_q <= '0;
                written_q  <= '0;
            end else begin
                if (tag_in)  accepted_q <= accepted_q + ONE;
                if (tag_out) written_q  <= written_q + ONE;
            end
            if (i_valid && !tag_in) begin
                err_q <= 1'b1;
            end else if ((state_q == ST_IDLE) && i_start) begin
                err_q <= 1'b0;
            end
            cenb_q <= !tag_out;
            if (tag_out) begin
                addr_q <= wr_addr;
                data_q <= row_aligned;
            end
        end
    end

    assign o_cenb = cenb_q;
    assign o_wenb = cenb_q;
    assign o_addr = addr_q;
    assign o_data = data_q;
    assign o_busy = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
    assign o_done = (state_q == ST_DONE);
    assign o_err  = err_q;

endmodule
